// File: rtl/dmem_wait_ctrl.sv
// Data-memory stage with a fixed number of wait states; one load/store in flight.
// Latency: response pulse in the cycle after accept edge + WAIT_CYCLES + 1.
// Backpressure: req_ready high only in IDLE; no backpressure on the response.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned access reports resp_err).
module dmem_wait_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int         DEPTH     = 1 << DEPTH_LOG2;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                accept;
  logic                do_access;
  logic                misaligned;
  logic [DEPTH_LOG2-1:0] idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign idx = addr_q[DEPTH_LOG2+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  assign misaligned = (addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Upper address bits wrap away; the low byte-offset bits only matter with the alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[ADDR_W-1:DEPTH_LOG2+2], addr_q[1:0]};

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down wait states, then one response cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_access = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request capture: inputs are sampled only on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Word array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (do_access && we_q && !misaligned) begin
      mem[idx] <= wdata_q;
    end
  end

  // Load data register; holds between responses, stores leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (do_access) begin
      if (misaligned) begin
        rdata_q <= '0;
      end else if (!we_q) begin
        rdata_q <= mem[idx];
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Misalignment flag captured on the access edge, presented during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (do_access) begin
      err_q <= misaligned;
    end
  end
  assign resp_err = (state_q == S_RESP) && err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: directed scenarios plus random traffic, all
// compared every cycle against an edge-counting transaction model.
module tb_dmem_wait_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dmem_wait_ctrl #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // One request in flight; its response belongs to edge accept+W+1 and the
  // block is free again after edge accept+W+2.
  int          edge_cnt = 0;
  int          acc_edge = 0;
  bit          m_busy = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] m_rdata = 0;
  bit          m_err = 0;
  logic [31:0] m_mem [1024];

  function automatic bit is_misaligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 0;
      m_rdata = 0;
      m_err   = 0;
    end else begin
      edge_cnt++;
      if (m_busy) begin
        if (edge_cnt == acc_edge + W + 1) begin
          m_err = is_misaligned(m_addr);
          if (m_err) m_rdata = 0;
          else if (m_we) m_mem[m_addr[11:2]] = m_wdata;
          else m_rdata = m_mem[m_addr[11:2]];
        end else if (edge_cnt == acc_edge + W + 2) begin
          m_busy = 0;
        end
      end else if (req_valid) begin
        m_busy   = 1;
        acc_edge = edge_cnt;
        m_we     = req_we;
        m_addr   = req_addr;
        m_wdata  = req_wdata;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_resp;
    exp_resp = m_busy && (edge_cnt == acc_edge + W + 1);
    chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp});
    chk("resp_err", {31'd0, resp_err}, {31'd0, exp_resp && m_err});
    chk("resp_rdata", resp_rdata, m_rdata);
  end

  // ---------------- stimulus helpers ----------------
  // Issue one request; returns data, error and posedges from accept to response.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int g;
    g = 0;
    rdata = 'x; err = 1'bx; lat = -1;
    @(negedge clk);
    while (!req_ready) begin
      g++;
      if (g > 100) begin
        chk("wait_ready_timeout", 32'(g), 32'd0);
        return;
      end
      @(negedge clk);
    end
    #1;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    #1;
    req_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 64);
    if (!resp_valid) chk("resp_timeout", 32'(lat), 32'(W + 1));
    rdata = resp_rdata;
    err = resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rdata", resp_rdata, 32'd0);
    #1 rst_n = 1;

    // preload the 16 words used by random traffic
    for (int i = 0; i < 16; i++) do_req(1, 32'(i * 4), 32'hC0FFEE00 ^ 32'(i * 32'h01010101), rd, er, lat);

    // store then load, latency W+1 posedges
    do_req(1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st_latency", 32'(lat), 32'd3);
    do_req(0, 32'h10, 32'h0, rd, er, lat);
    chk("ld_latency", 32'(lat), 32'd3);
    chk("ld_deadbeef", rd, 32'hDEADBEEF);
    chk("ld_err", {31'd0, er}, 32'd0);

    // store leaves resp_rdata unchanged
    do_req(1, 32'h14, 32'h11111111, rd, er, lat);
    chk("st_keeps_rdata", rd, 32'hDEADBEEF);

    // address wrap
    do_req(1, 32'h1000, 32'hA5A5A5A5, rd, er, lat);
    do_req(0, 32'h0, 32'h0, rd, er, lat);
    chk("wrap_load", rd, 32'hA5A5A5A5);

    // req_valid held through the access: second request starts after IDLE
    do_req(1, 32'h30, 32'h00001234, rd, er, lat);
    @(negedge clk); #1;
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    @(negedge clk); #1;
    req_addr = 32'h30;
    lat = 0;
    while (!resp_valid && lat < 64) begin @(negedge clk); lat++; end
    chk("hold_first_rdata", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    @(negedge clk); #1;
    req_valid = 0;
    lat = 2;
    while (!resp_valid && lat < 64) begin @(negedge clk); lat++; end
    chk("hold_second_rdata", resp_rdata, 32'h00001234);
    chk("hold_spacing", 32'(lat), 32'd5);

    // reset while a store is waiting with one wait state left
    do_req(1, 32'h20, 32'h00000055, rd, er, lat);
    @(negedge clk); #1;
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'h77;
    @(negedge clk); #1;
    req_valid = 0;
    @(negedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_resp", {31'd0, resp_valid}, 32'd0);
    #1 rst_n = 1;
    do_req(0, 32'h20, 32'h0, rd, er, lat);
    chk("reset_no_write", rd, 32'h00000055);

    // misaligned store
    do_req(1, 32'h22, 32'h00000099, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_err", {31'd0, er}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    do_req(0, 32'h20, 32'h0, rd, er, lat);
    chk("mis_unchanged", rd, 32'h00000055);
`else
    chk("mis_err", {31'd0, er}, 32'd0);
    do_req(0, 32'h20, 32'h0, rd, er, lat);
    chk("mis_written", rd, 32'h00000099);
`endif

    // random traffic, occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (!rst_n) begin
        rst_n = 1;
      end else if ($urandom_range(63) == 0) begin
        rst_n = 0;
      end else begin
        req_valid = ($urandom_range(1) == 1);
        req_we    = ($urandom_range(1) == 1);
        req_addr  = {$urandom_range(255) == 0 ? 20'($urandom) : 20'd0,
                     6'd0, 4'($urandom_range(15)),
                     ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'd0};
        req_wdata = $urandom;
      end
    end
    @(negedge clk); #1;
    req_valid = 0; rst_n = 1;
    repeat (W + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
